// File: rtl/exec_sequencer_pkg.sv
// proc_pkg: opcode constants, sequencer state encoding and instruction field
// widths shared by the exec_sequencer slice.
package proc_pkg;

    localparam int OPC_W = 4;
    localparam int REG_W = 3;
    localparam int IMM_W = 8;
    localparam int JMP_W = 4;

    localparam logic [OPC_W-1:0] OP_ADDI = 4'b0001;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'b0010;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'b0011;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'b1000;
    localparam logic [OPC_W-1:0] OP_BR   = 4'b1100;
    localparam logic [OPC_W-1:0] OP_OUT  = 4'b1111;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        WRITEBACK = 3'd4
    } state_t;

    // Opcode field of a 16-bit instruction word.
    function automatic logic [OPC_W-1:0] opcode_of(input logic [15:0] word);
        return word[15:12];
    endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// Datapath bus between exec_sequencer (master) and the regfile/ALU/ROM side
// (slave): ROM address and data, instruction register, write strobes, flags.
interface exec_sequencer_if;
    import proc_pkg::*;

    logic [15:0]      instruction;
    logic             alu_zero;
    logic [JMP_W-1:0] address;
    logic [15:0]      ir;
    logic             rf_we;
    logic             wb_sel;
    logic             out_we;
    logic             zero;

    modport master (
        input  instruction, alu_zero,
        output address, ir, rf_we, wb_sel, out_we, zero
    );

    modport slave (
        output instruction, alu_zero,
        input  address, ir, rf_we, wb_sel, out_we, zero
    );

endinterface

// File: rtl/exec_sequencer_tick_gen.sv
// tick_gen: free-running prescaler 0..TICK_DIV-1; tick is high while the
// count sits at its last value, so one tick every TICK_DIV cycles.
module tick_gen #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int               CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    // Prescaler count, wraps at LAST and never stops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (count == LAST)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle control sequencer for the 16-bit datapath.
// Owns the PC, instruction register, zero flag and all datapath strobes.
// Optional feature macro: BREAKPOINT_EN (adds bp_addr / bp_hit).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for run&&tick or step&&!run
// FETCH     | ir <= instruction at address
// DECODE    | regfile/ALU settle on the new ir
// EXECUTE   | alu_zero settles; WRITEBACK strobes are registered here
// WRITEBACK | strobes high for this cycle; PC, zero flag updated at its end
module exec_sequencer
    import proc_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int ROM_SIZE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step,
`ifdef BREAKPOINT_EN
    input  logic [JMP_W-1:0] bp_addr,
    output logic             bp_hit,
`endif
    output logic             busy,
    exec_sequencer_if.master bus
);
    state_t           state;
    logic             tick;
    logic             start;
    logic [OPC_W-1:0] opcode;
    logic [JMP_W:0]   pc_inc;
    logic [JMP_W-1:0] pc_seq;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign opcode = opcode_of(bus.ir);
    assign pc_inc = {1'b0, bus.address} + 1'b1;
    assign pc_seq = (pc_inc >= (JMP_W+1)'(ROM_SIZE)) ? '0 : pc_inc[JMP_W-1:0];

`ifdef BREAKPOINT_EN
    logic bp_match;
    logic bp_release;

    // A held breakpoint releases on step or on run dropping; that start then
    // executes the instruction that was suppressed.
    assign bp_match   = !bp_hit && run && tick && (bus.address == bp_addr);
    assign bp_release = bp_hit && (step || !run);
    assign start      = bp_release ||
                        (!bp_hit && ((run && tick && (bus.address != bp_addr)) ||
                                     (step && !run)));

    // Sticky breakpoint flag, only evaluated while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bp_hit <= 1'b0;
        else if (state == IDLE) begin
            if (bp_release)
                bp_hit <= 1'b0;
            else if (bp_match)
                bp_hit <= 1'b1;
        end
    end
`else
    assign start = (run && tick) || (step && !run);
`endif

    // Sequencer FSM with registered strobes, PC, ir and zero flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            bus.address <= '0;
            bus.ir      <= '0;
            bus.rf_we   <= 1'b0;
            bus.wb_sel  <= 1'b0;
            bus.out_we  <= 1'b0;
            bus.zero    <= 1'b0;
        end else begin
            bus.rf_we  <= 1'b0;
            bus.wb_sel <= 1'b0;
            bus.out_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FETCH;
                        busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    bus.ir <= bus.instruction;
                    state  <= DECODE;
                end
                DECODE: begin
                    state <= EXECUTE;
                end
                EXECUTE: begin
                    state <= WRITEBACK;
                    case (opcode)
                        OP_ADDI: begin
                            bus.rf_we  <= 1'b1;
                            bus.wb_sel <= 1'b1;
                        end
                        OP_ADD, OP_SUB: bus.rf_we  <= 1'b1;
                        OP_OUT:         bus.out_we <= 1'b1;
                        default: ;
                    endcase
                end
                WRITEBACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (opcode == OP_SUB)
                        bus.zero <= bus.alu_zero;
                    // Branch uses the flag as it stood before this cycle.
                    if ((opcode == OP_JMP) || ((opcode == OP_BR) && bus.zero))
                        bus.address <= bus.ir[11:8];
                    else
                        bus.address <= pc_seq;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
